fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage 16-bit pipeline.
- Owns the PC and drives the instruction-memory address.
- Consumes Stall from the decode-stage hazard unit and redirects (branch/jump) from execute.
- Feeds decode with an instruction, its PC+2 and a valid bit.
- A one-entry hold buffer keeps a fetched instruction when memory returns data during a stall.

---
 rtl/fetch_stage_pkg.sv | 28 ++
 rtl/fetch_stage_fd_pipe_reg.sv | 37 +++
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, pipeline constants and
// the IF/ID bundle layout used by both the IF/ID register and the hold buffer.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_HOLD   = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEFAULT    = 16'h0000;
  localparam logic [15:0] NOP_INSTR_DEFAULT   = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE_DEFAULT = 5'b00000;
  localparam logic [15:0] PC_INC_DEFAULT      = 16'd2;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_inc;
    logic        valid;
  } fd_bundle_t;

  localparam int FD_W = $bits(fd_bundle_t);

  function automatic logic is_halt(input logic [15:0] instr, input logic [4:0] opcode);
    return instr[15:11] == opcode;
  endfunction

endpackage

// File: rtl/fetch_stage_fd_pipe_reg.sv
// IF/ID-style register with enable, bubble insert and flush. Instantiated twice
// by fetch_stage: once as the IF/ID register and once as the one-entry hold buffer.
module fetch_stage_fd_pipe_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic            i_flush,
  input  logic            i_bubble,
  input  logic [FD_W-1:0] i_d,
  output logic [FD_W-1:0] o_q
);

  fd_bundle_t r_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q.instr  <= NOP_INSTR;
      r_q.pc_inc <= '0;
      r_q.valid  <= 1'b0;
    end else if (i_flush || (i_en && i_bubble)) begin
      // A bubble keeps the last PC+inc; only the word and valid bit change.
      r_q.instr <= NOP_INSTR;
      r_q.valid <= 1'b0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory, and feeds
// decode through the IF/ID register, parking one instruction when decode stalls.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [15:0] NOP_INSTR   = NOP_INSTR_DEFAULT,
  parameter logic [4:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT,
  parameter logic [15:0] PC_INC      = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  input  logic [15:0] IMemInstr,
  input  logic        IMemDone,
  output logic [15:0] IMemAddr,
  output logic        IMemRd,
  output logic [15:0] FD_Instr,
  output logic [15:0] FD_PCInc,
  output logic        FD_Valid,
  output logic        Halted
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [15:0]  r_pc;
  logic [15:0]  w_pc_next;
  logic [15:0]  w_pc_inc;

  fd_bundle_t   w_fetched;
  fd_bundle_t   w_fd;
  fd_bundle_t   w_fd_d;
  fd_bundle_t   w_buf;
  logic         w_fd_en;
  logic         w_fd_flush;
  logic         w_fd_bubble;
  logic         w_buf_en;
  logic         w_buf_flush;

  // 16-bit modulo: FFFE + 2 wraps to 0000 silently.
  assign w_pc_inc = r_pc + PC_INC;

  assign w_fetched.instr  = IMemInstr;
  assign w_fetched.pc_inc = w_pc_inc;
  assign w_fetched.valid  = 1'b1;

  // Priority: Redirect > Stall > IMemDone; rst is applied in the registers.
  // NOTE: every signal written here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_fd_en      = !Stall;
    w_fd_flush   = Redirect;
    w_fd_bubble  = 1'b1;
    w_fd_d       = w_fetched;
    w_buf_en     = 1'b0;
    w_buf_flush  = Redirect;

    if (Redirect) begin
      w_state_next = ST_FETCH;
      w_pc_next    = RedirectPC;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (IMemDone) begin
            w_pc_next   = w_pc_inc;
            w_fd_bubble = 1'b0;
            if (Stall) begin
              w_buf_en     = 1'b1;
              w_state_next = ST_HOLD;
            end else if (is_halt(IMemInstr, HALT_OPCODE)) begin
              w_state_next = ST_HALTED;
            end
          end
        end
        ST_HOLD: begin
          w_fd_bubble = 1'b0;
          w_fd_d      = w_buf;
          if (!Stall) begin
            w_buf_flush  = 1'b1;
            w_state_next = is_halt(w_buf.instr, HALT_OPCODE) ? ST_HALTED : ST_FETCH;
          end
        end
        ST_HALTED: begin
          // HALT advances once when unstalled; bubbles follow until redirect.
          w_fd_bubble = 1'b1;
        end
        default: begin
          w_state_next = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  fetch_stage_fd_pipe_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_fd_reg (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_fd_en),
    .i_flush  (w_fd_flush),
    .i_bubble (w_fd_bubble),
    .i_d      (w_fd_d),
    .o_q      (w_fd)
  );

  fetch_stage_fd_pipe_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_buf_en),
    .i_flush  (w_buf_flush),
    .i_bubble (1'b0),
    .i_d      (w_fetched),
    .o_q      (w_buf)
  );

  assign IMemAddr = r_pc;
  assign IMemRd   = (r_state == ST_FETCH) && !rst;
  assign Halted   = (r_state == ST_HALTED);
  assign FD_Instr = w_fd.instr;
  assign FD_PCInc = w_fd.pc_inc;
  assign FD_Valid = w_fd.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a directed walk through the main scenarios,
// then randomized stall/redirect/memory-latency traffic against a reference model.
module tb_fetch_stage;

  localparam logic [15:0] NOP      = 16'h0800;
  localparam logic [4:0]  HALT_OP  = 5'b00000;
  localparam logic [15:0] STEP     = 16'd2;
  localparam int          N_RANDOM = 3000;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        Stall      = 1'b0;
  logic        Redirect   = 1'b0;
  logic [15:0] RedirectPC = 16'h0000;
  logic [15:0] IMemInstr  = 16'h0000;
  logic        IMemDone   = 1'b0;
  logic [15:0] IMemAddr;
  logic        IMemRd;
  logic [15:0] FD_Instr;
  logic [15:0] FD_PCInc;
  logic        FD_Valid;
  logic        Halted;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .IMemInstr  (IMemInstr),
    .IMemDone   (IMemDone),
    .IMemAddr   (IMemAddr),
    .IMemRd     (IMemRd),
    .FD_Instr   (FD_Instr),
    .FD_PCInc   (FD_PCInc),
    .FD_Valid   (FD_Valid),
    .Halted     (Halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instructions accepted from memory but not yet handed to
  // decode, in program order, plus the fetch PC and the halted/parked flags.
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcinc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_pc        = 16'h0000;
  logic        m_parked    = 1'b0;
  logic [15:0] m_park_word = 16'h0000;
  logic        m_halted    = 1'b0;
  logic        m_fd_valid  = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst || Redirect) begin
      m_pc       = rst ? 16'h0000 : RedirectPC;
      m_parked   = 1'b0;
      m_halted   = 1'b0;
      m_fd_valid = 1'b0;
      sb.delete();
    end else if (m_parked) begin
      if (!Stall) begin
        m_parked   = 1'b0;
        m_fd_valid = 1'b1;
        m_halted   = (m_park_word[15:11] == HALT_OP);
      end
    end else if (m_halted) begin
      if (!Stall) m_fd_valid = 1'b0;
    end else if (IMemDone) begin
      sb.push_back('{instr: IMemInstr, pcinc: m_pc + STEP});
      m_pc = m_pc + STEP;
      if (Stall) begin
        m_parked    = 1'b1;
        m_park_word = IMemInstr;
      end else begin
        m_fd_valid = 1'b1;
        m_halted   = (IMemInstr[15:11] == HALT_OP);
      end
    end else if (!Stall) begin
      m_fd_valid = 1'b0;
    end
  end

  // Monitor: compares what decode sees each cycle; an instruction is consumed
  // when it is presented with Stall low.
  initial forever begin
    @(negedge clk);
    check("imem_addr", IMemAddr, m_pc);
    check("imem_rd", IMemRd, !rst && !m_parked && !m_halted);
    check("halted", Halted, m_halted);
    check("fd_valid", FD_Valid, m_fd_valid);
    if (!m_fd_valid) begin
      check("bubble_instr", FD_Instr, NOP);
    end else if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty: got %h expected none at %0t", FD_Instr, $time);
    end else begin
      check("fd_instr", FD_Instr, sb[0].instr);
      check("fd_pcinc", FD_PCInc, sb[0].pcinc);
      if (!Stall) void'(sb.pop_front());
    end
  end

  task automatic set_in(input logic r, input logic s, input logic rd, input logic [15:0] rpc,
                        input logic d, input logic [15:0] ins);
    rst        = r;
    Stall      = s;
    Redirect   = rd;
    RedirectPC = rpc;
    IMemDone   = d;
    IMemInstr  = ins;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ins;
    logic [15:0] rpc;

    // Reset
    set_in(1, 0, 0, 16'h0000, 0, 16'h0000);
    tick(); tick();
    check("rst_addr", IMemAddr, 16'h0000);
    check("rst_valid", FD_Valid, 1'b0);
    check("rst_instr", FD_Instr, NOP);
    check("rst_pcinc", FD_PCInc, 16'h0000);
    check("rst_halted", Halted, 1'b0);

    // Straight-line fetch
    set_in(0, 0, 0, 16'h0000, 1, 16'h4001); tick();
    check("f1_instr", FD_Instr, 16'h4001);
    check("f1_pcinc", FD_PCInc, 16'h0002);
    check("f1_addr", IMemAddr, 16'h0002);
    set_in(0, 0, 0, 16'h0000, 1, 16'h4002); tick();
    check("f2_instr", FD_Instr, 16'h4002);
    check("f2_pcinc", FD_PCInc, 16'h0004);
    check("f2_addr", IMemAddr, 16'h0004);

    // Data returns during a stall: parked, then released
    set_in(0, 1, 0, 16'h0000, 1, 16'h5123); tick();
    check("hold_frozen", FD_Instr, 16'h4002);
    check("hold_rd", IMemRd, 1'b0);
    set_in(0, 1, 0, 16'h0000, 0, 16'h0000); tick(); tick();
    check("hold_frozen2", FD_Instr, 16'h4002);
    set_in(0, 0, 0, 16'h0000, 0, 16'h0000); tick();
    check("rel_instr", FD_Instr, 16'h5123);
    check("rel_pcinc", FD_PCInc, 16'h0006);
    check("rel_addr", IMemAddr, 16'h0006);
    check("rel_rd", IMemRd, 1'b1);

    // Redirect beats Stall and IMemDone
    set_in(0, 1, 1, 16'h0100, 1, 16'h1234); tick();
    check("redir_addr", IMemAddr, 16'h0100);
    check("redir_valid", FD_Valid, 1'b0);
    check("redir_instr", FD_Instr, NOP);
    check("redir_rd", IMemRd, 1'b1);

    // HALT at PC=8
    set_in(0, 0, 1, 16'h0008, 0, 16'h0000); tick();
    set_in(0, 0, 0, 16'h0000, 1, 16'h0000); tick();
    check("halt_instr", FD_Instr, 16'h0000);
    check("halt_flag", Halted, 1'b1);
    check("halt_rd", IMemRd, 1'b0);
    check("halt_addr", IMemAddr, 16'h000A);
    set_in(0, 0, 0, 16'h0000, 1, 16'h7777); tick();
    check("halt_bubble", FD_Valid, 1'b0);
    check("halt_pc_frozen", IMemAddr, 16'h000A);
    tick();
    check("halt_still", Halted, 1'b1);
    set_in(0, 0, 1, 16'h0020, 0, 16'h0000); tick();
    check("unhalt_flag", Halted, 1'b0);
    check("unhalt_addr", IMemAddr, 16'h0020);

    // Memory latency bubbles
    set_in(0, 0, 0, 16'h0000, 0, 16'h0000); tick(); tick();
    check("lat_valid", FD_Valid, 1'b0);
    check("lat_instr", FD_Instr, NOP);
    check("lat_addr", IMemAddr, 16'h0020);
    set_in(0, 0, 0, 16'h0000, 1, 16'h6A5A); tick();
    check("lat_fetch", FD_Instr, 16'h6A5A);
    check("lat_pcinc", FD_PCInc, 16'h0022);

    // PC wrap at the top of the address space
    set_in(0, 0, 1, 16'hFFFE, 0, 16'h0000); tick();
    set_in(0, 0, 0, 16'h0000, 1, 16'h4444); tick();
    check("wrap_pcinc", FD_PCInc, 16'h0000);
    check("wrap_addr", IMemAddr, 16'h0000);

    // Reset while parked
    set_in(0, 1, 0, 16'h0000, 1, 16'h4555); tick();
    check("park_rd", IMemRd, 1'b0);
    set_in(1, 1, 0, 16'h0000, 0, 16'h0000); tick();
    check("rst_hold_addr", IMemAddr, 16'h0000);
    check("rst_hold_valid", FD_Valid, 1'b0);
    set_in(0, 0, 0, 16'h0000, 0, 16'h0000); tick();
    check("rst_hold_rd", IMemRd, 1'b1);
    check("rst_hold_nobuf", FD_Valid, 1'b0);

    // Randomized traffic
    for (int i = 0; i < N_RANDOM; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 11) == 0) ins[15:11] = HALT_OP;
      else if (ins[15:11] == HALT_OP) ins[15:11] = 5'd1;
      rpc = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 9) == 0) rpc = 16'hFFFE;
      set_in($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 7, rpc, $urandom_range(0, 99) < 60, ins);
      tick();
    end

    set_in(0, 0, 0, 16'h0000, 0, 16'h0000);
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
